// File: rtl/stream_packer_flush_if.sv
// stream_packer_flush_if: beat input, flush controls and FIFO output bus of the packer.
// Ports (signals):
//   valid_in/data_in       beat strobe and data from the LVDS deserialiser
//   flush_en/flush_req     idle-timeout flush enable, immediate partial flush request
//   out_valid/out_ready    ready/valid handshake of the FIFO head
//   data_out/keep_out      head word and its lane-valid mask
//   fifo_level             words queued
//   overflow/drop_cnt      sticky drop flag and saturating drop count
// Modports: master drives beats and consumes words; slave is the packer.
interface stream_packer_flush_if #(
    parameter int LVDS_LEN   = 8,
    parameter int DATA_LEN   = 32,
    parameter int FIFO_DEPTH = 4
);
    localparam int R = DATA_LEN / LVDS_LEN;

    logic                          valid_in;
    logic [LVDS_LEN-1:0]           data_in;
    logic                          flush_en;
    logic                          flush_req;
    logic                          out_valid;
    logic                          out_ready;
    logic [DATA_LEN-1:0]           data_out;
    logic [R-1:0]                  keep_out;
    logic [$clog2(FIFO_DEPTH):0]   fifo_level;
    logic                          overflow;
    logic [15:0]                   drop_cnt;

    modport master (
        output valid_in, data_in, flush_en, flush_req, out_ready,
        input  out_valid, data_out, keep_out, fifo_level, overflow, drop_cnt
    );

    modport slave (
        input  valid_in, data_in, flush_en, flush_req, out_ready,
        output out_valid, data_out, keep_out, fifo_level, overflow, drop_cnt
    );
endinterface

// File: rtl/stream_packer_flush.sv
// stream_packer_flush: packs LVDS beats into words (lane 0 first) with timeout/forced partial flush and a ready/valid output FIFO.
// Ports:
//   clk    receiver clock
//   rst_n  synchronous reset, active low
//   bus    stream_packer_flush_if.slave: beat input, flush controls, FIFO head and overflow accounting
module stream_packer_flush #(
    parameter int LVDS_LEN      = 8,
    parameter int DATA_LEN      = 32,
    parameter int FLUSH_TIMEOUT = 16,
    parameter int FIFO_DEPTH    = 4
) (
    input logic                    clk,
    input logic                    rst_n,
    stream_packer_flush_if.slave   bus
);
    localparam int R  = DATA_LEN / LVDS_LEN;
    localparam int CW = $clog2(R + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = DATA_LEN + R;

    typedef enum logic {EMPTY, FILL} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       lane_q, lane_d, lane_n;
    logic [15:0]         idle_q, idle_d, idle_inc;
    logic [DATA_LEN-1:0] asm_q, asm_d, asm_w;
    logic [R-1:0]        keep_w;
    logic                push, timeout;

    // One-word stage between packer and FIFO: a push at edge N lands in the FIFO at N+1.
    logic                pkt_vld_q;
    logic [EW-1:0]       pkt_q;

    logic [EW-1:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_q, rd_q;
    logic [LW-1:0]       level_q, level_d;
    logic                overflow_q;
    logic [15:0]         drop_q, drop_d;
    logic                pop, accept, drop;

    always_comb begin
        asm_w = asm_q;
        for (int i = 0; i < R; i++) begin
            if (bus.valid_in && lane_q == CW'(i)) asm_w[i*LVDS_LEN +: LVDS_LEN] = bus.data_in;
        end
        lane_n = lane_q + CW'(bus.valid_in);
        for (int i = 0; i < R; i++) keep_w[i] = CW'(i) < lane_n;
        idle_inc = (idle_q == 16'hFFFF) ? idle_q : idle_q + 16'd1;
        // Timeout only in idle cycles; >= lets a late flush_en catch an already-expired count.
        timeout = state_q == FILL && !bus.valid_in && bus.flush_en && idle_inc >= 16'(FLUSH_TIMEOUT);
        // lane_n == 0 means nothing is assembled, so an empty word is never pushed.
        push = lane_n == CW'(R) || (bus.flush_req && lane_n != '0) || timeout;
        state_d = (push || lane_n == '0) ? EMPTY : FILL;
        lane_d = push ? '0 : lane_n;
        asm_d = push ? '0 : asm_w;
        idle_d = (push || bus.valid_in || state_q == EMPTY) ? '0 : idle_inc;
    end

    always_comb begin
        pop = level_q != '0 && bus.out_ready;
        // A full FIFO still takes the word if the head leaves in the same cycle.
        accept = pkt_vld_q && (level_q != LW'(FIFO_DEPTH) || pop);
        drop = pkt_vld_q && !accept;
        level_d = level_q + LW'(accept) - LW'(pop);
        drop_d = (drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            lane_q     <= '0;
            idle_q     <= '0;
            asm_q      <= '0;
            pkt_vld_q  <= 1'b0;
            pkt_q      <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            idle_q     <= idle_d;
            asm_q      <= asm_d;
            pkt_vld_q  <= push;
            pkt_q      <= {keep_w, asm_w};
            wr_q       <= wr_q + AW'(accept);
            rd_q       <= rd_q + AW'(pop);
            level_q    <= level_d;
            overflow_q <= overflow_q | drop;
            drop_q     <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem_q[wr_q] <= pkt_q;
    end

    assign bus.out_valid                = level_q != '0;
    assign {bus.keep_out, bus.data_out} = bus.out_valid ? mem_q[rd_q] : '0;
    assign bus.fifo_level               = level_q;
    assign bus.overflow                 = overflow_q;
    assign bus.drop_cnt                 = drop_q;
endmodule

// File: tb/tb_stream_packer_flush.sv
// tb_stream_packer_flush: directed self-checking bench for stream_packer_flush.
module tb_stream_packer_flush;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    logic [35:0] got [$];

    stream_packer_flush_if bus ();

    stream_packer_flush dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) got.push_back({bus.keep_out, bus.data_out});
    end

    task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic beat(logic [7:0] b);
        bus.valid_in = 1'b1;
        bus.data_in  = b;
        step();
        bus.valid_in = 1'b0;
    endtask

    function automatic logic [35:0] w(int k);
        return got.size() > k ? got[k] : '1;
    endfunction

    initial begin
        bus.valid_in  = 1'b0;
        bus.data_in   = '0;
        bus.flush_en  = 1'b0;
        bus.flush_req = 1'b0;
        bus.out_ready = 1'b0;
        step(2);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_data", bus.data_out, 0);
        chk("rst_keep", bus.keep_out, 0);
        chk("rst_level", bus.fifo_level, 0);
        chk("rst_ovf", bus.overflow, 0);
        chk("rst_drop", bus.drop_cnt, 0);
        rst_n = 1'b1;

        bus.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            beat(8'(i));
            if (i == 4) chk("t1_lat_edge_n", bus.out_valid, 0);
            if (i == 5) chk("t1_lat_edge_n1", bus.out_valid, 1);
        end
        step(4);
        chk("t1_count", got.size(), 2);
        chk("t1_w0", w(0), {4'hF, 32'h04030201});
        chk("t1_w1", w(1), {4'hF, 32'h08070605});
        got.delete();

        bus.flush_en = 1'b1;
        beat(8'hAA); beat(8'hBB); beat(8'hCC);
        step(16);
        chk("t2_no_flush_16", bus.out_valid, 0);
        step(1);
        chk("t2_flush_17", bus.out_valid, 1);
        step(3);
        chk("t2_count", got.size(), 1);
        chk("t2_word", w(0), {4'b0111, 32'h00CCBBAA});
        got.delete();

        bus.flush_en = 1'b0;
        beat(8'hAA); beat(8'hBB); beat(8'hCC);
        step(100);
        chk("t2_noen_count", got.size(), 0);
        chk("t2_noen_level", bus.fifo_level, 0);
        bus.flush_req = 1'b1;
        step();
        bus.flush_req = 1'b0;
        step(4);
        chk("t2_req_count", got.size(), 1);
        chk("t2_req_word", w(0), {4'b0111, 32'h00CCBBAA});
        got.delete();

        bus.flush_en = 1'b1;
        beat(8'hFF); beat(8'h00);
        step(5);
        beat(8'hFF); beat(8'h00);
        step(4);
        chk("t3_count", got.size(), 1);
        chk("t3_word", w(0), {4'hF, 32'h00FF00FF});
        got.delete();

        beat(8'h10); beat(8'h20); beat(8'h30);
        bus.flush_req = 1'b1;
        beat(8'h40);
        bus.flush_req = 1'b0;
        step(5);
        chk("t4_count", got.size(), 1);
        chk("t4_word", w(0), {4'hF, 32'h40302010});
        got.delete();
        bus.flush_req = 1'b1;
        step();
        bus.flush_req = 1'b0;
        step(1);
        chk("t4_empty_level", bus.fifo_level, 0);
        step(3);
        chk("t4_empty_count", got.size(), 0);
        bus.flush_req = 1'b1;
        beat(8'h55);
        bus.flush_req = 1'b0;
        step(4);
        chk("t4_single_count", got.size(), 1);
        chk("t4_single_word", w(0), {4'b0001, 32'h00000055});
        got.delete();

        bus.out_ready = 1'b0;
        for (int i = 0; i < 24; i++) beat(8'(i));
        step(3);
        chk("t5_level", bus.fifo_level, 4);
        chk("t5_ovf", bus.overflow, 1);
        chk("t5_drop", bus.drop_cnt, 2);
        chk("t5_valid", bus.out_valid, 1);
        chk("t5_head", bus.data_out, 32'h03020100);
        bus.out_ready = 1'b1;
        step(8);
        chk("t5_count", got.size(), 4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("t5_w%0d", k), w(k),
                {4'hF, 8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
        chk("t5_drained", bus.fifo_level, 0);
        chk("t5_ovf_sticky", bus.overflow, 1);
        got.delete();

        bus.out_ready = 1'b0;
        for (int i = 1; i <= 10; i++) beat(8'(i));
        step(1);
        chk("t6_pre_level", bus.fifo_level, 2);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t6_valid", bus.out_valid, 0);
        chk("t6_level", bus.fifo_level, 0);
        chk("t6_ovf", bus.overflow, 0);
        chk("t6_drop", bus.drop_cnt, 0);
        bus.out_ready = 1'b1;
        beat(8'h11); beat(8'h22); beat(8'h33); beat(8'h44);
        step(4);
        chk("t6_count", got.size(), 1);
        chk("t6_word", w(0), {4'hF, 32'h44332211});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
